// File: rtl/ti_packet_parser.sv
// ti_packet_parser: splits routing/size/header/payload flits, holds a supported header
// for the consumer and passes the payload straight through; bad packets are drained.
module ti_packet_parser #(
    parameter int FLIT_SIZE   = 32,
    parameter int HEADER_SIZE = 13
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             rx_i,
    input  logic [FLIT_SIZE-1:0]             data_i,
    output logic                             credit_o,
    output logic                             header_valid_o,
    input  logic                             header_ack_i,
    output logic [HEADER_SIZE*FLIT_SIZE-1:0] header_o,
    output logic [FLIT_SIZE-1:0]             service_o,
    output logic [FLIT_SIZE-1:0]             payload_size_o,
    output logic                             payload_valid_o,
    input  logic                             payload_ready_i,
    output logic [FLIT_SIZE-1:0]             payload_o,
    output logic                             payload_last_o,
    output logic                             drop_o,
    output logic                             error_o
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SIZE    = 3'd1;
    localparam logic [2:0] S_HEADER  = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_PAYLOAD = 3'd4;
    localparam logic [2:0] S_DRAIN   = 3'd5;
    localparam int IW = (HEADER_SIZE > 1) ? $clog2(HEADER_SIZE) : 1;
    localparam logic [FLIT_SIZE-1:0] HS = FLIT_SIZE'(HEADER_SIZE);
    localparam logic [10*32-1:0] SVC = {32'h00, 32'h01, 32'h10, 32'h23, 32'h26,
                                        32'h31, 32'h34, 32'h40, 32'h70, 32'h71};

    logic [2:0]                         r_state;
    logic [FLIT_SIZE-1:0]               r_size;
    logic [FLIT_SIZE-1:0]               r_cnt;
    logic [IW-1:0]                      r_idx;
    logic [HEADER_SIZE*FLIT_SIZE-1:0]   r_hbuf;
    logic [HEADER_SIZE*FLIT_SIZE-1:0]   r_header;
    logic [FLIT_SIZE-1:0]               r_service;
    logic [FLIT_SIZE-1:0]               r_payload_size;
    logic                               r_drop;
    logic                               r_error;

    logic                               w_xfer;
    logic                               w_last_word;
    logic                               w_supported;
    logic [HEADER_SIZE*FLIT_SIZE-1:0]   w_hdr_next;
    logic [FLIT_SIZE-1:0]               w_service;
    logic [FLIT_SIZE-1:0]               w_rem;

    assign credit_o        = (r_state == S_HOLD) ? 1'b0 : (r_state == S_PAYLOAD) ? payload_ready_i : 1'b1;
    assign w_xfer          = rx_i & credit_o;
    assign w_last_word     = (r_idx == IW'(HEADER_SIZE - 1));
    assign w_rem           = r_size - HS;
    assign header_valid_o  = (r_state == S_HOLD);
    assign header_o        = r_header;
    assign service_o       = r_service;
    assign payload_size_o  = r_payload_size;
    assign payload_valid_o = (r_state == S_PAYLOAD) & rx_i;
    assign payload_o       = data_i;
    assign payload_last_o  = (r_state == S_PAYLOAD) && (r_cnt == FLIT_SIZE'(1));
    assign drop_o          = r_drop;
    assign error_o         = r_error;

    // Header words collect in a staging buffer so header_o only changes on entry to HOLD.
    always_comb begin
        w_hdr_next = r_hbuf;
        w_hdr_next[r_idx*FLIT_SIZE +: FLIT_SIZE] = data_i;
        w_service = w_hdr_next[FLIT_SIZE-1:0];
        w_supported = 1'b0;
        for (int k = 0; k < 10; k++)
            w_supported = w_supported | (w_service == FLIT_SIZE'(SVC[k*32 +: 32]));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= S_IDLE;
            r_size         <= '0;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_hbuf         <= '0;
            r_header       <= '0;
            r_service      <= '0;
            r_payload_size <= '0;
            r_drop         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_drop  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: if (w_xfer) r_state <= S_SIZE;
                S_SIZE: if (w_xfer) begin
                    if (data_i < HS) begin
                        r_error <= 1'b1;
                        r_cnt   <= data_i;
                        r_state <= (data_i == '0) ? S_IDLE : S_DRAIN;
                    end else begin
                        r_size  <= data_i;
                        r_idx   <= '0;
                        r_state <= S_HEADER;
                    end
                end
                S_HEADER: if (w_xfer) begin
                    r_hbuf <= w_hdr_next;
                    r_idx  <= r_idx + 1'b1;
                    if (w_last_word) begin
                        if (w_supported) begin
                            r_header       <= w_hdr_next;
                            r_service      <= w_service;
                            r_payload_size <= w_rem;
                            r_state        <= S_HOLD;
                        end else begin
                            r_drop  <= 1'b1;
                            r_cnt   <= w_rem;
                            r_state <= (w_rem == '0) ? S_IDLE : S_DRAIN;
                        end
                    end
                end
                S_HOLD: if (header_ack_i) begin
                    r_cnt   <= r_payload_size;
                    r_state <= (r_payload_size == '0) ? S_IDLE : S_PAYLOAD;
                end
                S_PAYLOAD, S_DRAIN: if (w_xfer) begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == FLIT_SIZE'(1)) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ti_packet_parser.sv
// tb_ti_packet_parser: directed packets with hand-computed expectations.
module tb_ti_packet_parser;
    localparam int FW = 32;
    localparam int HN = 13;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              rx_i = 1'b0;
    logic [FW-1:0]     data_i = '0;
    logic              credit_o;
    logic              header_valid_o;
    logic              header_ack_i = 1'b0;
    logic [HN*FW-1:0]  header_o;
    logic [FW-1:0]     service_o;
    logic [FW-1:0]     payload_size_o;
    logic              payload_valid_o;
    logic              payload_ready_i = 1'b0;
    logic [FW-1:0]     payload_o;
    logic              payload_last_o;
    logic              drop_o;
    logic              error_o;

    int n_tests = 0;
    int n_fail  = 0;

    ti_packet_parser #(.FLIT_SIZE(FW), .HEADER_SIZE(HN)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .rx_i(rx_i), .data_i(data_i), .credit_o(credit_o),
        .header_valid_o(header_valid_o), .header_ack_i(header_ack_i), .header_o(header_o),
        .service_o(service_o), .payload_size_o(payload_size_o), .payload_valid_o(payload_valid_o),
        .payload_ready_i(payload_ready_i), .payload_o(payload_o), .payload_last_o(payload_last_o),
        .drop_o(drop_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] hw(input logic [FW-1:0] svc, input int tag, input int i);
        return (i == 0) ? svc : FW'((tag << 8) | i);
    endfunction

    // One flit, waiting (bounded) for credit; returns 1 ns after the transferring edge.
    task automatic send(input logic [FW-1:0] d);
        int w;
        @(negedge clk_i);
        rx_i = 1'b1;
        data_i = d;
        #1;
        w = 0;
        while (!credit_o && w < 50) begin
            @(negedge clk_i);
            #1;
            w++;
        end
        if (!credit_o) chk("credit_timeout", 0, 1);
        @(posedge clk_i);
        #1;
        rx_i = 1'b0;
    endtask

    task automatic send_hdr(input logic [FW-1:0] svc, input int s, input int tag);
        send(FW'(32'hAA00 + tag));
        send(FW'(s));
        for (int i = 0; i < HN; i++) send(hw(svc, tag, i));
    endtask

    task automatic ack();
        @(negedge clk_i);
        header_ack_i = 1'b1;
        @(posedge clk_i);
        #1;
        header_ack_i = 1'b0;
    endtask

    // Payload with ready toggling each cycle and rx held high.
    task automatic payload(input int n, input logic [FW-1:0] base);
        int idx = 0;
        int cyc = 0;
        logic rdy = 1'b0;
        while (idx < n && cyc < 4 * n + 4) begin
            @(negedge clk_i);
            rx_i = 1'b1;
            data_i = base + FW'(idx);
            payload_ready_i = rdy;
            #1;
            chk("pl_credit", credit_o, rdy);
            chk("pl_valid", payload_valid_o, 1);
            chk("pl_data", payload_o, base + FW'(idx));
            chk("pl_last", payload_last_o, idx == n - 1);
            @(posedge clk_i);
            if (rdy) idx++;
            rdy = ~rdy;
            cyc++;
        end
        if (idx < n) chk("pl_timeout", idx, n);
        @(negedge clk_i);
        #1;
        chk("pl_after_valid", payload_valid_o, 0);
        rx_i = 1'b0;
        payload_ready_i = 1'b0;
    endtask

    initial begin
        logic [HN*FW-1:0] held;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_hv", header_valid_o, 0);
        chk("rst_hdr", header_o[63:0], 0);
        chk("rst_svc", service_o, 0);
        chk("rst_psize", payload_size_o, 0);
        chk("rst_pulses", {drop_o, error_o, payload_valid_o, payload_last_o}, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("rst_credit", credit_o, 1);

        // S=15 service 0x40: two payload flits
        send_hdr(32'h40, 15, 1);
        chk("a_hv", header_valid_o, 1);
        chk("a_svc", service_o, 32'h40);
        chk("a_psize", payload_size_o, 2);
        chk("a_word5", header_o[5*FW +: FW], 32'h0105);
        chk("a_word12", header_o[12*FW +: FW], 32'h010C);
        held = header_o;
        repeat (10) @(posedge clk_i);
        #1;
        chk("hold_credit", credit_o, 0);
        chk("hold_stable", header_o == held, 1);
        chk("hold_hv", header_valid_o, 1);
        ack();
        chk("a_hv_off", header_valid_o, 0);
        payload(2, 32'hD000);

        // S=13 service 0x10: no payload
        send_hdr(32'h10, 13, 2);
        chk("b_hv", header_valid_o, 1);
        chk("b_psize", payload_size_o, 0);
        ack();
        chk("b_idle_hv", header_valid_o, 0);
        @(negedge clk_i);
        rx_i = 1'b1;
        #1;
        chk("b_no_pv", payload_valid_o, 0);
        chk("b_idle_credit", credit_o, 1);
        rx_i = 1'b0;

        // S=16 service 0x99: dropped, 3 flits drained
        send_hdr(32'h99, 16, 3);
        chk("c_drop", drop_o, 1);
        chk("c_err", error_o, 0);
        chk("c_hv", header_valid_o, 0);
        chk("c_hdr_kept", header_o[FW +: FW], 32'h0201);
        @(posedge clk_i);
        #1;
        chk("c_drop_pulse", drop_o, 0);
        for (int i = 0; i < 3; i++) begin
            send(32'hE0 + 32'(i));
            chk("c_drain_credit", credit_o, 1);
            chk("c_drain_hv", header_valid_o, 0);
        end

        // S=5: error, drain 5, then S=14 service 0x71
        send(32'hAA04);
        send(32'd5);
        chk("d_err", error_o, 1);
        chk("d_drop", drop_o, 0);
        @(posedge clk_i);
        #1;
        chk("d_err_pulse", error_o, 0);
        for (int i = 0; i < 5; i++) send(32'hF0 + 32'(i));
        send_hdr(32'h71, 14, 5);
        chk("e_hv", header_valid_o, 1);
        chk("e_svc", service_o, 32'h71);
        chk("e_psize", payload_size_o, 1);
        ack();
        payload(1, 32'hB000);

        // S=0: error straight back to IDLE
        send(32'hAA06);
        send(32'd0);
        chk("z_err", error_o, 1);
        send_hdr(32'h01, 13, 7);
        chk("z_hv", header_valid_o, 1);
        chk("z_svc", service_o, 32'h01);
        ack();

        // Reset during header word 6
        send(32'hAA08);
        send(32'd15);
        for (int i = 0; i < 6; i++) send(hw(32'h26, 8, i));
        @(negedge clk_i);
        rx_i = 1'b1;
        data_i = hw(32'h26, 8, 6);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("r_hdr", header_o[FW +: FW], 0);
        chk("r_svc", service_o, 0);
        chk("r_psize", payload_size_o, 0);
        chk("r_flags", {header_valid_o, payload_valid_o, payload_last_o, drop_o, error_o}, 0);
        chk("r_credit", credit_o, 1);
        rx_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        send_hdr(32'h23, 13, 9);
        chk("r_hv", header_valid_o, 1);
        chk("r_svc2", service_o, 32'h23);
        chk("r_word12", header_o[12*FW +: FW], 32'h090C);
        chk("r_psize2", payload_size_o, 0);
        ack();
        chk("r_idle", credit_o, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
